// File: rtl/tri_nor_idle_det.sv
// tri_nor_idle_det -- multi-channel NOR activity detector with filtered idle.
//
// Each channel NOR-reduces its WIDTH activity bits into a registered quiet
// flag (nor_q). A saturating per-channel counter then qualifies the quiet
// flag for IDLE_CYC consecutive cycles before raising idle. A one-cycle
// idle_pulse marks each rising edge of idle.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active high
//   act         activity bits; channel c owns act[c*WIDTH : c*WIDTH+WIDTH-1]
//   force_busy  treat every channel as active this cycle
//   en          detector enable; 0 clears counters and idle outputs
//   nor_q       registered per-channel NOR of act (0 while force_busy)
//   idle        per-channel filtered idle
//   idle_pulse  one-cycle pulse when idle rises
//   all_idle    AND of all idle bits
//
// Parameter constraints: IDLE_CYC >= 1 and 2**CNT_WIDTH > IDLE_CYC.

// Per-channel slice: quiet flag register plus qualification counter.
module tri_nor_idle_det_ch #(
  parameter int WIDTH     = 3,
  parameter int IDLE_CYC  = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_act,
  input  logic             i_force_busy,
  input  logic             i_en,
  output logic             o_nor_q,
  output logic             o_idle,
  output logic             o_idle_pulse
);
  // One extra bit so cnt+1 never wraps before the threshold compare.
  localparam logic [CNT_WIDTH:0]   LP_IDLE_W = (CNT_WIDTH+1)'(IDLE_CYC);
  localparam logic [CNT_WIDTH-1:0] LP_IDLE_C = CNT_WIDTH'(IDLE_CYC);

  logic                 r_nor_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_idle;
  logic                 r_pulse;
  logic [CNT_WIDTH:0]   w_cnt_inc;
  logic                 w_reach;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_reach   = (w_cnt_inc >= LP_IDLE_W);
  // Saturate at IDLE_CYC so a long quiet stretch holds rather than wraps.
  assign w_cnt_nxt = w_reach ? LP_IDLE_C : w_cnt_inc[CNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nor_q <= 1'b0;
      r_cnt   <= '0;
      r_idle  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      // Stage 1 runs regardless of en so the flag is valid when en returns.
      r_nor_q <= ~(|i_act) & ~i_force_busy;
      if (!i_en || !r_nor_q) begin
        r_cnt   <= '0;
        r_idle  <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_idle  <= w_reach;
        r_pulse <= w_reach & ~r_idle;
      end
    end
  end

  assign o_nor_q      = r_nor_q;
  assign o_idle       = r_idle;
  assign o_idle_pulse = r_pulse;
endmodule

module tri_nor_idle_det #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 3,
  parameter int IDLE_CYC  = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:CHANNELS*WIDTH-1] act,
  input  logic                      force_busy,
  input  logic                      en,
  output logic [0:CHANNELS-1]       nor_q,
  output logic [0:CHANNELS-1]       idle,
  output logic [0:CHANNELS-1]       idle_pulse,
  output logic                      all_idle
);
  genvar c, b;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] w_act_ch;
      for (b = 0; b < WIDTH; b++) begin : g_bit
        assign w_act_ch[b] = act[c*WIDTH + b];
      end
      tri_nor_idle_det_ch #(
        .WIDTH     (WIDTH),
        .IDLE_CYC  (IDLE_CYC),
        .CNT_WIDTH (CNT_WIDTH)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .i_act        (w_act_ch),
        .i_force_busy (force_busy),
        .i_en         (en),
        .o_nor_q      (nor_q[c]),
        .o_idle       (idle[c]),
        .o_idle_pulse (idle_pulse[c])
      );
    end
  endgenerate

  assign all_idle = &idle;
endmodule
